// File: rtl/spi_adc_master.sv
// SPI master for ADC register access: 24-bit mode-0 frames, MSB first, with
// 16-bit readback returned as {12'h000, addr, data}.
module spi_adc_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrlen,
    input  logic        rw,
    input  logic [3:0]  addr,
    input  logic [15:0] sdata,
    input  logic        spi_miso,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [2:0]  stmon
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] TOP_BIT  = 5'd23;

    state_t      r_state, w_state_next;
    logic [7:0]  r_div, w_div_next;
    logic [4:0]  r_bit, w_bit_next;
    logic        r_sclk, w_sclk_next;
    logic [23:0] r_shift;
    logic [15:0] r_cap;
    logic        r_rw;
    logic [3:0]  r_addr;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_rvalid;
    logic        r_ctrlen_d;

    logic w_start, w_div_last, w_load, w_shift_en, w_capture, w_finish;

    assign w_start    = ctrlen & ~r_ctrlen_d;
    assign w_div_last = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_div_next   = w_div_last ? 8'd0 : r_div + 8'd1;
        w_bit_next   = r_bit;
        w_sclk_next  = r_sclk;
        w_load       = 1'b0;
        w_shift_en   = 1'b0;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div_next = 8'd0;
                if (w_start) begin
                    w_state_next = ST_SETUP;
                    w_bit_next   = TOP_BIT;
                    w_load       = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_div_last) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_div_last) begin
                    if (!r_sclk) begin
                        w_sclk_next = 1'b1;
                        w_capture   = 1'b1;
                    end else begin
                        w_sclk_next = 1'b0;
                        if (r_bit == 5'd0) begin
                            w_state_next = ST_HOLD;
                        end else begin
                            w_bit_next = r_bit - 5'd1;
                            w_shift_en = 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_div_last) begin
                    w_state_next = ST_GAP;
                    w_finish     = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_div_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bit 23 is presented from SETUP onward; later bits advance on each SCLK fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= 8'd0;
            r_bit      <= 5'd0;
            r_sclk     <= 1'b0;
            r_shift    <= 24'h0;
            r_cap      <= 16'h0;
            r_rw       <= 1'b0;
            r_addr     <= 4'h0;
            r_rdata    <= 32'h0;
            r_done     <= 1'b0;
            r_rvalid   <= 1'b0;
            r_ctrlen_d <= 1'b0;
        end else begin
            r_ctrlen_d <= ctrlen;
            r_div      <= w_div_next;
            r_bit      <= w_bit_next;
            r_sclk     <= w_sclk_next;
            r_done     <= w_finish;
            r_rvalid   <= w_finish & r_rw;
            if (w_load) begin
                r_shift <= {rw, 3'b000, addr, rw ? 16'h0000 : sdata};
                r_rw    <= rw;
                r_addr  <= addr;
                r_cap   <= 16'h0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[22:0], 1'b0};
            end
            if (w_capture) r_cap <= {r_cap[14:0], spi_miso};
            if (w_finish && r_rw) r_rdata <= {12'h000, r_addr, r_cap};
        end
    end

    assign spi_csb  = (r_state == ST_IDLE) || (r_state == ST_GAP);
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_shift[23];
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign stmon    = r_state;

endmodule
